// File: rtl/lcd_dbg_frame_builder.sv
// Purpose: snapshot CPU/RAM debug state on a refresh edge and stream it as a 2x16 uppercase-hex ASCII frame.
// Latency: first character valid the cycle after the capturing edge; 32 accepted chars, then one frame_done cycle.
// Backpressure: char_valid/char_data/char_pos are registers and hold while char_ready is low; refresh edges outside IDLE are dropped.
module lcd_dbg_frame_builder #(
  parameter int NUM_REGS       = 12,
  parameter bit SKIP_UNCHANGED = 1'b1
) (
  input  logic        qzt_clk,
  input  logic        reset,
  input  logic        refresh,
  input  logic        switch_flag,
  input  logic [3:0]  dbg_reg,
  input  logic [95:0] cpu_interface,
  input  logic [7:0]  ram_addr,
  input  logic [7:0]  ram_data,
  input  logic        char_ready,
  output logic        char_valid,
  output logic [7:0]  char_data,
  output logic [4:0]  char_pos,
  output logic        busy,
  output logic        frame_done
);

  // Fixed frame text; variable fields are blanks overwritten by f_glyph.
  localparam logic [255:0] CPU_TXT = {"CPU ", "  ", " = ", "  ", "     ", "REG #", " ", "          "};
  localparam logic [255:0] RAM_TXT = {"RAM ADDR = ", "     ", "RAM DATA = ", "     "};
  localparam logic [191:0] NAMES   = "PCIRSTW Z A B C SPADDODI";

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

  state_t      r_state;
  logic        r_refresh_q;
  logic [16:0] r_snap;
  logic [16:0] r_last;
  logic        r_last_vld;
  logic        r_char_valid;
  logic [7:0]  r_char_data;
  logic [4:0]  r_char_pos;
  logic        r_busy;
  logic        r_frame_done;

  logic [7:0]  w_sel;
  logic [16:0] w_content;
  logic        w_req;
  logic        w_skip;

  // Snapshot layout: {view, addr-or-{0,index}, data-or-field}; an invalid
  // index displays no field value, so its byte is forced to zero so that
  // unrelated field changes cannot defeat the unchanged-frame skip.
  function automatic logic [7:0] f_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] f_glyph(input logic [16:0] snap, input logic [4:0] pos);
    logic [7:0] g;
    logic       ok;
    int         p;
    int         k;
    p  = int'(pos);
    k  = int'(snap[11:8]);
    ok = (k < NUM_REGS) && (k < 12);
    if (!ok) k = 0;
    if (snap[16]) begin
      g = RAM_TXT[8*(31-p) +: 8];
      case (pos)
        5'd11:   g = f_hex(snap[15:12]);
        5'd12:   g = f_hex(snap[11:8]);
        5'd27:   g = f_hex(snap[7:4]);
        5'd28:   g = f_hex(snap[3:0]);
        default: ;
      endcase
    end else begin
      g = CPU_TXT[8*(31-p) +: 8];
      case (pos)
        5'd4:    g = ok ? NAMES[8*(23-2*k) +: 8] : 8'h3F;
        5'd5:    g = ok ? NAMES[8*(22-2*k) +: 8] : 8'h3F;
        5'd9:    g = ok ? f_hex(snap[7:4]) : 8'h2D;
        5'd10:   g = ok ? f_hex(snap[3:0]) : 8'h2D;
        5'd21:   g = f_hex(snap[11:8]);
        default: ;
      endcase
    end
    return g;
  endfunction

  // Live displayed content: selected CPU field or RAM address/data.
  always_comb begin
    w_sel = 8'h00;
    for (int i = 0; i < 12; i++) begin
      if ((int'(dbg_reg) == i) && (i < NUM_REGS)) w_sel = cpu_interface[8*i +: 8];
    end
    w_content = switch_flag ? {1'b1, ram_addr, ram_data} : {1'b0, 4'h0, dbg_reg, w_sel};
  end

  assign w_req  = refresh & ~r_refresh_q;
  assign w_skip = SKIP_UNCHANGED && r_last_vld && (w_content == r_last);

  // Frame sequencer: capture on request, stream 32 glyphs, pulse done, remember frame.
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_refresh_q  <= 1'b0;
      r_snap       <= '0;
      r_last       <= '0;
      r_last_vld   <= 1'b0;
      r_char_valid <= 1'b0;
      r_char_data  <= 8'h00;
      r_char_pos   <= 5'd0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_refresh_q  <= refresh;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req && !w_skip) begin
            r_snap       <= w_content;
            r_char_pos   <= 5'd0;
            r_char_data  <= f_glyph(w_content, 5'd0);
            r_char_valid <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (char_ready) begin
            if (r_char_pos == 5'd31) begin
              r_char_valid <= 1'b0;
              r_frame_done <= 1'b1;
              r_last       <= r_snap;
              r_last_vld   <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_char_pos  <= r_char_pos + 5'd1;
              r_char_data <= f_glyph(r_snap, r_char_pos + 5'd1);
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign char_valid = r_char_valid;
  assign char_data  = r_char_data;
  assign char_pos   = r_char_pos;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd_dbg_frame_builder.sv
// Bench for lcd_dbg_frame_builder: frames are predicted as 32-char strings
// from the inputs at request time and compared character by character.
module tb_lcd_dbg_frame_builder;
  logic        qzt_clk = 1'b0;
  logic        reset = 1'b1;
  logic        refresh = 1'b0;
  logic        switch_flag = 1'b0;
  logic [3:0]  dbg_reg = 4'd0;
  logic [95:0] cpu_interface = '0;
  logic [7:0]  ram_addr = 8'h00;
  logic [7:0]  ram_data = 8'h00;
  logic        char_ready = 1'b1;
  logic        char_valid;
  logic [7:0]  char_data;
  logic [4:0]  char_pos;
  logic        busy;
  logic        frame_done;

  lcd_dbg_frame_builder dut (
    .qzt_clk(qzt_clk), .reset(reset), .refresh(refresh), .switch_flag(switch_flag),
    .dbg_reg(dbg_reg), .cpu_interface(cpu_interface), .ram_addr(ram_addr),
    .ram_data(ram_data), .char_ready(char_ready), .char_valid(char_valid),
    .char_data(char_data), .char_pos(char_pos), .busy(busy), .frame_done(frame_done)
  );

  always #10 qzt_clk = ~qzt_clk;

  int         checks = 0;
  int         errors = 0;
  string      q[$];
  string      cur = "";
  string      m_last = "";
  bit         m_last_vld = 0;
  bit         in_frame = 0;
  bit         exp_done = 0;
  bit         pend;
  int         m_pos = 0;
  int         frames_done = 0;
  logic [7:0] cap [32];
  logic [7:0] e;
  string      NAMES [12] = '{"PC","IR","ST","W ","Z ","A ","B ","C ","SP","AD","DO","DI"};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic string hx(input logic [3:0] n);
    string t;
    t = "0123456789ABCDEF";
    return t.substr(int'(n), int'(n));
  endfunction

  function automatic string hh(input logic [7:0] b);
    return {hx(b[7:4]), hx(b[3:0])};
  endfunction

  // Reference rendering of the frame the current inputs must produce.
  function automatic string render();
    if (switch_flag)
      return {"RAM ADDR = ", hh(ram_addr), "   ", "RAM DATA = ", hh(ram_data), "   "};
    if (dbg_reg < 4'd12)
      return {"CPU ", NAMES[int'(dbg_reg)], " = ", hh(cpu_interface[int'(dbg_reg)*8 +: 8]),
              "     REG #", hx(dbg_reg), "          "};
    return {"CPU ?? = --     REG #", hx(dbg_reg), "          "};
  endfunction

  // Compare process: every cycle, outside reset.
  always @(negedge qzt_clk) begin
    if (reset) begin
      in_frame   = 0;
      exp_done   = 0;
      m_last_vld = 0;
    end else begin
      pend     = exp_done;
      exp_done = 0;
      chk("frame_done", 32'(frame_done), 32'(pend));
      if (pend) begin
        m_last     = cur;
        m_last_vld = 1;
        frames_done++;
      end
      if (char_valid && !in_frame) begin
        if (q.size() == 0) begin
          chk("unexpected_frame", 32'(char_valid), 32'd0);
        end else begin
          cur      = q.pop_front();
          in_frame = 1;
          m_pos    = 0;
        end
      end
      if (!char_valid && in_frame) chk("valid_held", 32'(char_valid), 32'd1);
      chk("busy", 32'(busy), 32'(in_frame || pend));
      if (char_valid && in_frame) begin
        e = cur[m_pos];
        chk("char_pos", 32'(char_pos), 32'(m_pos));
        chk("char_data", 32'(char_data), 32'(e));
        cap[m_pos] = char_data;
        if (char_ready) begin
          m_pos++;
          if (m_pos == 32) begin
            in_frame = 0;
            exp_done = 1;
          end
        end
      end
    end
  end

  task automatic request(input bit hold, output bit em);
    string s;
    s  = render();
    em = !(m_last_vld && (s == m_last));
    if (em) q.push_back(s);
    @(posedge qzt_clk); #1;
    refresh = 1'b1;
    @(posedge qzt_clk);
    @(negedge qzt_clk);
    chk("start_valid", 32'(char_valid), 32'(em));
    @(posedge qzt_clk); #1;
    if (!hold) refresh = 1'b0;
    if (!em) begin
      repeat (8) begin
        @(negedge qzt_clk);
        chk("skip_quiet", 32'(char_valid), 32'd0);
      end
    end
  endtask

  task automatic wait_frame(input bit rnd, input bit bp, input bit tog);
    int n0;
    bit ok;
    bit bpd;
    int togst;
    n0 = frames_done; ok = 0; bpd = 0; togst = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge qzt_clk); #1;
      if (frames_done != n0) begin ok = 1; break; end
      if (rnd) char_ready = 1'($urandom_range(0, 1));
      if (tog) begin
        if (togst == 1) begin refresh = 1'b0; togst = 2; end
        else if (togst == 0 && char_valid && char_pos == 5'd15) begin refresh = 1'b1; togst = 1; end
      end
      if (bp && !bpd && char_valid && char_pos == 5'd4) begin
        char_ready = 1'b0;
        repeat (3) begin
          @(negedge qzt_clk);
          chk("bp_pos", 32'(char_pos), 32'd4);
          chk("bp_data", 32'(char_data), 32'h41);
          chk("bp_valid", 32'(char_valid), 32'd1);
          @(posedge qzt_clk); #1;
        end
        char_ready = 1'b1;
        bpd = 1;
      end
    end
    char_ready = 1'b1;
    chk("frame_complete", 32'(ok), 32'd1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit    em;
    bit    hit;
    string s;
    repeat (3) @(posedge qzt_clk);
    #1;
    chk("rst_valid", 32'(char_valid), 32'd0);
    chk("rst_data", 32'(char_data), 32'd0);
    chk("rst_pos", 32'(char_pos), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    reset = 1'b0;

    // 1: CPU view, field A = 0x3C
    cpu_interface        = 96'h0123_4567_89AB_CDEF_0011_2233;
    cpu_interface[47:40] = 8'h3C;
    dbg_reg = 4'd5; switch_flag = 1'b0;
    s = render();
    chk("model_pos4", 32'(s[4]), 32'h41);
    chk("model_pos10", 32'(s[10]), 32'h43);
    request(0, em);
    wait_frame(0, 0, 0);
    chk("t1_pos4", 32'(cap[4]), 32'h41);
    chk("t1_pos5", 32'(cap[5]), 32'h20);
    chk("t1_pos9", 32'(cap[9]), 32'h33);
    chk("t1_pos10", 32'(cap[10]), 32'h43);
    chk("t1_pos21", 32'(cap[21]), 32'h35);

    // 2: RAM view
    switch_flag = 1'b1; ram_addr = 8'hA7; ram_data = 8'h0F;
    request(0, em);
    wait_frame(0, 0, 0);
    chk("t2_pos11", 32'(cap[11]), 32'h41);
    chk("t2_pos12", 32'(cap[12]), 32'h37);
    chk("t2_pos27", 32'(cap[27]), 32'h30);
    chk("t2_pos28", 32'(cap[28]), 32'h46);

    // 3: backpressure at position 4
    switch_flag = 1'b0;
    request(0, em);
    wait_frame(0, 1, 0);

    // 4: invalid register index
    dbg_reg = 4'd12;
    request(0, em);
    wait_frame(0, 0, 0);
    chk("t4_pos4", 32'(cap[4]), 32'h3F);
    chk("t4_pos5", 32'(cap[5]), 32'h3F);
    chk("t4_pos9", 32'(cap[9]), 32'h2D);
    chk("t4_pos10", 32'(cap[10]), 32'h2D);
    chk("t4_pos21", 32'(cap[21]), 32'h43);

    // 5: unchanged-frame suppression
    dbg_reg = 4'd5;
    request(0, em);
    wait_frame(0, 0, 0);
    request(0, em);
    chk("t5_same_skipped", 32'(em), 32'd0);
    cpu_interface[47:40] = 8'h3D;
    request(0, em);
    chk("t5_change_emits", 32'(em), 32'd1);
    wait_frame(0, 0, 0);
    chk("t5_pos10", 32'(cap[10]), 32'h44);
    cpu_interface[7:0] = 8'h99;
    request(0, em);
    chk("t5_unselected_skipped", 32'(em), 32'd0);

    // 6: reset mid-frame, then unchanged inputs still emit
    cpu_interface[47:40] = 8'h11;
    request(0, em);
    hit = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge qzt_clk); #1;
      if (char_valid && char_pos == 5'd10) begin hit = 1; break; end
    end
    chk("t6_reached_pos10", 32'(hit), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(char_valid), 32'd0);
    chk("t6_rst_data", 32'(char_data), 32'd0);
    chk("t6_rst_pos", 32'(char_pos), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(frame_done), 32'd0);
    repeat (2) @(posedge qzt_clk);
    #1;
    reset = 1'b0;
    request(0, em);
    chk("t6_post_reset_emits", 32'(em), 32'd1);
    wait_frame(0, 0, 0);

    // refresh edge during EMIT is ignored
    cpu_interface[47:40] = 8'h22;
    request(0, em);
    wait_frame(0, 0, 1);
    // refresh held high gives one frame only
    cpu_interface[47:40] = 8'h33;
    request(1, em);
    wait_frame(0, 0, 0);
    repeat (20) begin
      @(negedge qzt_clk);
      chk("hold_single", 32'(char_valid), 32'd0);
    end
    @(posedge qzt_clk); #1;
    refresh = 1'b0;

    // randomized frames with random ready
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) != 0) begin
        switch_flag   = 1'($urandom_range(0, 1));
        dbg_reg       = 4'($urandom_range(0, 15));
        cpu_interface = {$urandom, $urandom, $urandom};
        ram_addr      = 8'($urandom);
        ram_data      = 8'($urandom);
      end
      request(0, em);
      if (em) wait_frame(1, 0, 0);
    end

    repeat (4) @(posedge qzt_clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
